// File: rtl/ifetch_queue.sv
// Instruction fetch stage: one outstanding imem request at a time, returned
// {pc, instr} pairs buffered in a DEPTH-entry FIFO toward decode.
module ifetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              flush,
    output logic              pc_hold,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_req_pc;
    logic [ADDR_W-1:0] r_pc_mem  [DEPTH];
    logic [DATA_W-1:0] r_ins_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [PW:0]       r_count;
    logic              w_push, w_pop, w_latch;

    // A request only starts with a free slot, so a response always fits.
    assign w_latch = (r_state == IDLE) && !flush && (r_count < CNT_FULL);
    assign w_push  = (r_state == WAIT) && imem_rvalid && !flush;
    assign w_pop   = (r_count != '0) && id_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_latch) w_state_nxt = REQ;
            REQ: begin
                if (imem_gnt)   w_state_nxt = flush ? DRAIN : WAIT;
                else if (flush) w_state_nxt = IDLE;
            end
            WAIT: begin
                if (imem_rvalid) w_state_nxt = IDLE;
                else if (flush)  w_state_nxt = DRAIN;
            end
            DRAIN:   if (imem_rvalid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_req_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) r_req_pc <= fetch_addr;
        end
    end

    // Flush beats push/pop; the push is already masked by flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_pc_mem[r_wr_ptr]  <= r_req_pc;
            r_ins_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req  = (r_state == REQ);
    assign imem_addr = r_req_pc;
    assign pc_hold   = !w_push;
    assign id_valid  = (r_count != '0);
    assign id_pc     = id_valid ? r_pc_mem[r_rd_ptr]  : '0;
    assign id_instr  = id_valid ? r_ins_mem[r_rd_ptr] : '0;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with literal expectations, then
// randomized memory/decode/flush traffic checked against a transaction-level model.
module tb_ifetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset, flush, imem_gnt, imem_rvalid, id_ready;
    logic [AW-1:0] fetch_addr, imem_addr, id_pc;
    logic [DW-1:0] imem_rdata, id_instr;
    logic          pc_hold, imem_req, id_valid;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .flush(flush),
        .pc_hold(pc_hold), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
    );

    typedef struct {logic [AW-1:0] pc; logic [DW-1:0] instr;} ent_t;

    int checks = 0, errors = 0;

    // Reference: queue of delivered pairs plus the life of the single fetch.
    ent_t          m_q[$];
    bit            m_req_out, m_inflight, m_keep;
    logic [AW-1:0] m_pc;

    // Memory and sequencer environment.
    bit            mem_pend = 0;
    int            mem_cnt = 0;
    logic [DW-1:0] mem_data;
    int            gnt_pct = 100, dly_fix = 0;
    bit            data_fix = 0;
    logic [DW-1:0] data_val;
    bit            adv = 0, chk_en = 0;
    logic [AW-1:0] redir;
    logic          hold_s;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        ent_t h;
        bit   v;
        v = (m_q.size() != 0);
        if (v) h = m_q[0];
        else begin h.pc = '0; h.instr = '0; end
        chk("imem_req", imem_req, m_req_out);
        if (m_req_out) chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", id_valid, v);
        chk("id_pc", id_pc, h.pc);
        chk("id_instr", id_instr, h.instr);
        chk("pc_hold", pc_hold, !(m_inflight && m_keep && imem_rvalid && !flush));
    endtask

    task automatic model_edge();
        bit   pop, push;
        int   n;
        ent_t e;
        if (reset) begin
            m_q.delete(); m_req_out = 0; m_inflight = 0; m_keep = 0; m_pc = '0;
            return;
        end
        n    = m_q.size();
        pop  = (n != 0) && id_ready;
        push = m_inflight && m_keep && imem_rvalid && !flush;
        e.pc = m_pc; e.instr = imem_rdata;
        if (!m_req_out && !m_inflight) begin
            if (!flush && n < DEPTH) begin m_req_out = 1; m_pc = fetch_addr; end
        end else if (m_req_out) begin
            if (imem_gnt) begin m_req_out = 0; m_inflight = 1; m_keep = !flush; end
            else if (flush) m_req_out = 0;
        end else begin
            if (imem_rvalid) m_inflight = 0;
            else if (flush)  m_keep = 0;
        end
        if (flush) m_q.delete();
        else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(e);
        end
    endtask

    task automatic drive_mem();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
        if (mem_pend && mem_cnt == 0) begin
            imem_rvalid = 1; imem_rdata = mem_data;
        end else if (!reset && imem_req && !mem_pend && ($urandom_range(99) < gnt_pct))
            imem_gnt = 1;
    endtask

    task automatic env_edge();
        if (imem_rvalid) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (imem_gnt) begin
            mem_pend = 1;
            mem_cnt  = (dly_fix < 0) ? int'($urandom_range(3)) : dly_fix;
            mem_data = data_fix ? data_val : $urandom;
        end
        adv = !hold_s;
    endtask

    // One clock: entered and left just after a falling edge.
    task automatic tick();
        if (flush) fetch_addr = redir;
        else if (adv) fetch_addr = fetch_addr + 4;
        drive_mem();
        #1;
        hold_s = pc_hold;
        if (chk_en) check_cycle();
        @(posedge clk);
        model_edge();
        env_edge();
        @(negedge clk);
    endtask

    task automatic set_pc(input logic [AW-1:0] a);
        fetch_addr = a; adv = 0;
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, " imem_req"}, imem_req, 0);
        chk({tag, " imem_addr"}, imem_addr, 0);
        chk({tag, " id_valid"}, id_valid, 0);
        chk({tag, " id_pc"}, id_pc, 0);
        chk({tag, " id_instr"}, id_instr, 0);
    endtask

    initial begin
        logic [AW-1:0] got[$];
        logic [AW-1:0] resume_addr;
        bit            seen;
        int            ready_pct;

        reset = 1; flush = 0; id_ready = 0; fetch_addr = '0; redir = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        @(negedge clk);
        tick();
        chk_en = 1;
        tick();
        chk_reset_outs("reset");
        chk("reset pc_hold", hold_s, 1);
        reset = 0;

        // Single fetch
        id_ready = 1; data_fix = 1; data_val = 32'h2002_0001;
        tick(); chk("sf req", imem_req, 1); chk("sf addr", imem_addr, 0);
        tick(); chk("sf req drop", imem_req, 0);
        tick(); chk("sf hold", hold_s, 0); chk("sf valid", id_valid, 1);
                chk("sf pc", id_pc, 0); chk("sf instr", id_instr, 32'h2002_0001);
        tick(); chk("sf hold after", hold_s, 1); chk("sf popped", id_valid, 0);
        data_fix = 0;

        // Fill and drain
        reset = 1; tick(); reset = 0;
        set_pc('0); id_ready = 0;
        repeat (16) tick();
        chk("full valid", id_valid, 1); chk("full head", id_pc, 0);
        chk("full no req", imem_req, 0); chk("full hold", hold_s, 1);
        id_ready = 1; seen = 0; resume_addr = '1;
        repeat (5) begin
            if (id_valid) got.push_back(id_pc);
            tick();
            if (imem_req && !seen) begin seen = 1; resume_addr = imem_addr; end
        end
        while (got.size() < 4) got.push_back('1);
        for (int i = 0; i < 4; i++) chk("drain order", got[i], 64'(i * 4));
        chk("resume addr", resume_addr, 32'h10);

        // Flush while waiting for data
        reset = 1; tick(); reset = 0;
        set_pc('0); id_ready = 0;
        repeat (7) tick();
        dly_fix = 2; data_fix = 1; data_val = 32'hDEAD_BEEF;
        tick();
        dly_fix = 0; data_fix = 0;
        chk("fw waiting", imem_req, 0); chk("fw queued", id_valid, 1);
        flush = 1; redir = 32'h40; tick(); flush = 0;
        chk("fw cleared", id_valid, 0);
        tick(); chk("fw drain req", imem_req, 0);
        tick(); chk("fw discard", id_valid, 0); chk("fw instr", id_instr, 0);
        tick(); chk("fw refetch", imem_req, 1); chk("fw refetch addr", imem_addr, 32'h40);

        // Flush in REQ, with and without grant
        reset = 1; tick(); reset = 0;
        gnt_pct = 0; id_ready = 1; set_pc(32'h20);
        tick(); chk("fr req", imem_req, 1);
        flush = 1; redir = 32'h80; tick(); flush = 0;
        chk("fr withdrawn", imem_req, 0);
        tick(); chk("fr no drain", imem_req, 1); chk("fr addr", imem_addr, 32'h80);
        gnt_pct = 100; dly_fix = 1;
        flush = 1; redir = 32'hC0; tick(); flush = 0; dly_fix = 0;
        chk("fg drain", imem_req, 0);
        tick(); chk("fg still drain", imem_req, 0);
        tick(); chk("fg discarded", id_valid, 0); chk("fg idle", imem_req, 0);
        tick(); chk("fg refetch", imem_req, 1); chk("fg addr", imem_addr, 32'hC0);

        // Simultaneous push and pop
        reset = 1; tick(); reset = 0;
        set_pc('0); id_ready = 0;
        repeat (8) tick();
        chk("pp head0", id_pc, 0);
        id_ready = 1;
        tick(); chk("pp pushed", hold_s, 0); chk("pp head1", id_pc, 4);
        tick(); chk("pp head2", id_pc, 8);
        tick(); chk("pp empty", id_valid, 0);

        // Reset with a fetch outstanding
        reset = 1; tick(); reset = 0;
        set_pc(32'h100); id_ready = 1; dly_fix = 3;
        tick(); tick(); dly_fix = 0;
        chk("rw waiting", imem_req, 0);
        reset = 1; tick(); reset = 0;
        chk_reset_outs("rw reset");
        set_pc(32'h200);
        tick(); chk("rw req", imem_req, 1); chk("rw addr", imem_addr, 32'h200);
        tick(); tick();
        chk("rw stray ignored", id_valid, 0); chk("rw still req", imem_req, 1);
        tick(); tick();
        chk("rw valid", id_valid, 1); chk("rw pc", id_pc, 32'h200);

        // Randomized traffic
        gnt_pct = 60; dly_fix = -1;
        for (int i = 0; i < 3000; i++) begin
            ready_pct = ((i / 500) % 2) ? 20 : 80;
            reset = ($urandom_range(199) == 0);
            flush = !reset && ($urandom_range(24) == 0);
            if (flush) redir = $urandom & 32'hFFFF_FFFC;
            id_ready = ($urandom_range(99) < ready_pct);
            tick();
        end
        reset = 0; flush = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage directly downstream of the program sequencer.
- Takes the current PC (fetch_addr) and issues one request at a time to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned {pc, instruction} pairs in a DEPTH-entry FIFO for decode (valid/ready).
- Tells the sequencer when to advance (pc_hold); discards all in-flight work on a branch redirect (flush).

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
fetch_addr  in  ADDR_W  current PC from sequencer
flush  in  1  branch redirect (sequencer pc_src); discard queue and outstanding fetch
pc_hold  out  1  1 = sequencer must not advance PC; redirect always overrides hold in the sequencer
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid; earliest the cycle after gnt, exactly one per grant
imem_rdata  in  DATA_W  instruction word
id_valid  out  1  head entry valid
id_instr  out  DATA_W  head instruction, 0 when id_valid=0
id_pc  out  ADDR_W  head PC, 0 when id_valid=0
id_ready  in  1  decode accepts head this cycle

Behaviour:
- Reset: state=IDLE, FIFO empty (pointers/count 0), req_pc=0.
  - Outputs: imem_req=0, imem_addr=0, id_valid=0, id_instr=0, id_pc=0, pc_hold=1.
  - Reset mid-transaction goes straight to IDLE with no DRAIN; imem_rvalid in IDLE is ignored.
- At most one outstanding request. FSM states IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - If !flush and count < DEPTH: latch req_pc <= fetch_addr, go to REQ.
  - flush in IDLE: stay IDLE, no latch.
- REQ:
  - imem_req=1, imem_addr=req_pc (registered).
  - gnt & !flush -> WAIT.
  - flush & gnt -> DRAIN.
  - flush & !gnt -> IDLE (request withdrawn; memory protocol permits withdrawal before grant).
- WAIT:
  - imem_req=0.
  - rvalid & !flush: push {req_pc, imem_rdata}, -> IDLE.
  - rvalid & flush: data discarded, -> IDLE.
  - flush & !rvalid -> DRAIN.
- DRAIN: on rvalid discard data, -> IDLE. Further flushes have no additional effect.
- Slot reservation: a request starts only when count < DEPTH. Count cannot increase while a request is outstanding, so every response has a free slot; no overflow possible.
- pc_hold: combinational, = !(state==WAIT & imem_rvalid & !flush).
  - It is 0 exactly in the cycle a response is pushed; the sequencer advances on that edge.
  - The next IDLE cycle latches the new PC.
- Minimum fetch cadence: one instruction per 3 cycles (IDLE, REQ, WAIT with gnt and rvalid each on first opportunity).
- FIFO:
  - Circular buffer, wr/rd pointers wrap modulo DEPTH, count 0..DEPTH.
  - Not fall-through: a pushed entry is visible (id_valid=1) the cycle after the push edge.
  - Pop when id_valid & id_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance. Pop while empty is ignored.
- Flush has priority over push and pop: pointers and count cleared on the flush edge; id_valid=0 the next cycle.
- Full (count==DEPTH): no new request, pc_hold=1 until a pop frees a slot. A request then starts with one cycle of latency (IDLE sees count<DEPTH).
- Order preserved: id_pc sequence equals the sequence of fetch_addr values latched.

Test Plan:
- Single fetch:
  - Stimulus: release reset, fetch_addr=0x0, gnt in first REQ cycle, rvalid next cycle with 0x20020001, id_ready=1.
  - Response: imem_req=1 with imem_addr=0 for one cycle; pc_hold=0 for exactly one cycle; next cycle id_valid=1, id_pc=0x0, id_instr=0x20020001; popped, id_valid=0.
- Fill and drain:
  - Stimulus: id_ready=0, sequencer model advancing by 4, immediate gnt/rvalid.
  - Response: 4 entries (pc 0x0,0x4,0x8,0xC); imem_req stays 0 and pc_hold=1 while full; id_ready=1 drains in order; fetching resumes at 0x10.
- Flush in WAIT:
  - Stimulus: granted fetch of 0x8 outstanding, 2 entries queued; pulse flush with fetch_addr=0x40; rvalid arrives 2 cycles later with 0xDEADBEEF.
  - Response: id_valid=0 the cycle after flush; 0xDEADBEEF never appears at decode; next imem_addr=0x40.
- Flush in REQ without gnt:
  - Response: imem_req=0 the next cycle, FSM in IDLE, no DRAIN.
  - Flush coincident with gnt: FSM enters DRAIN and discards the subsequent response.
- Simultaneous push and pop:
  - Stimulus: count=2, id_ready=1 in the push cycle.
  - Response: count stays 2; head advances to next pc; tail holds new entry; no loss or duplication.
- Reset mid-WAIT:
  - Stimulus: assert reset with a fetch outstanding; memory returns rvalid after reset deasserts.
  - Response: all outputs at reset values; stray rvalid ignored; FIFO empty; next request uses the current fetch_addr.
